// File: rtl/freq_meter_pkg.sv
// Shared constants and FSM state type for the frequency-meter display path.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package freq_meter_pkg;

  localparam int NDIG     = 4;     // display digits
  localparam int DIG_W    = 4;     // bits per BCD digit
  localparam int MAX_DISP = 9999;  // largest value the 4 digits can show

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/freq_bcd_conv_if.sv
// Handshake and digit bus between the gate counter, the BCD converter and the scanner.
// Latency: n/a (wires only).
// Backpressure: none; start is only honoured while the converter is idle.
// Signals: start/bin (request, driven by master), busy/done/ovf/dig1..dig4 (result, driven by slave).
interface freq_bcd_conv_if #(
  parameter int BIN_W = 14
);
  import freq_meter_pkg::*;

  logic             start;
  logic [BIN_W-1:0] bin;
  logic             busy;
  logic             done;
  logic             ovf;
  logic [DIG_W-1:0] dig1;
  logic [DIG_W-1:0] dig2;
  logic [DIG_W-1:0] dig3;
  logic [DIG_W-1:0] dig4;

  modport master (
    output start, bin,
    input  busy, done, ovf, dig1, dig2, dig3, dig4
  );

  modport slave (
    input  start, bin,
    output busy, done, ovf, dig1, dig2, dig3, dig4
  );

endinterface

// File: rtl/bcd_adj3.sv
// Double-dabble correction cell: adds 3 to a BCD nibble that is 5 or more.
// Latency: combinational.
// Backpressure: none.
// Ports: i_nib (nibble before shift), o_nib (corrected nibble).
module bcd_adj3
  import freq_meter_pkg::*;
(
  input  logic [DIG_W-1:0] i_nib,
  output logic [DIG_W-1:0] o_nib
);

  assign o_nib = (i_nib >= DIG_W'(5)) ? (i_nib + DIG_W'(3)) : i_nib;

endmodule

// File: rtl/freq_bcd_conv.sv
// Iterative binary-to-BCD converter feeding the 4-digit 7-segment scanner; saturates at 9999 with ovf.
// Latency: BIN_W+1 cycles from accepted start to done; one conversion per BIN_W+2 cycles at best.
// Backpressure: start is ignored (not queued) while busy; digits hold between conversions.
// Ports: clk, rst (sync, active-high); bus.slave carries start/bin in, busy/done/ovf/dig1..dig4 out.
module freq_bcd_conv
  import freq_meter_pkg::*;
#(
  parameter int BIN_W = 14
) (
  input  logic                 clk,
  input  logic                 rst,
  freq_bcd_conv_if.slave       bus
);

  localparam int               BCD_W    = NDIG * DIG_W;
  localparam int               CNT_W    = $clog2(BIN_W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIN_W - 1);
  localparam logic [BIN_W-1:0] MAX_BIN  = BIN_W'(MAX_DISP);

  state_t             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [BIN_W-1:0]   r_sr;
  logic [BCD_W-1:0]   r_bcd;
  logic               r_ovf_pend;
  logic               r_ovf;
  logic               r_done;
  logic [BCD_W-1:0]   r_dig;
  logic [BCD_W-1:0]   w_adj;

  // Correct every nibble before the shift so each doubles into a valid BCD digit.
  for (genvar g = 0; g < NDIG; g++) begin : g_adj
    bcd_adj3 u_adj (
      .i_nib (r_bcd[g*DIG_W +: DIG_W]),
      .o_nib (w_adj[g*DIG_W +: DIG_W])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_sr       <= '0;
      r_bcd      <= '0;
      r_ovf_pend <= 1'b0;
      r_ovf      <= 1'b0;
      r_done     <= 1'b0;
      r_dig      <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.start) begin
            r_sr       <= bus.bin;
            r_bcd      <= '0;
            r_cnt      <= '0;
            r_ovf_pend <= (bus.bin > MAX_BIN);
            r_state    <= SHIFT;
          end
        end
        SHIFT: begin
          // Carry out of the top BCD bit only happens for out-of-range inputs, which saturate.
          r_bcd <= {w_adj[BCD_W-2:0], r_sr[BIN_W-1]};
          r_sr  <= r_sr << 1;
          r_cnt <= r_cnt + CNT_W'(1);
          if (r_cnt == CNT_LAST) begin
            r_state <= DONE;
          end
        end
        DONE: begin
          r_dig   <= r_ovf_pend ? {NDIG{DIG_W'(9)}} : r_bcd;
          r_ovf   <= r_ovf_pend;
          r_done  <= 1'b1;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.busy = (r_state != IDLE);
  assign bus.done = r_done;
  assign bus.ovf  = r_ovf;
  assign bus.dig1 = r_dig[0*DIG_W +: DIG_W];
  assign bus.dig2 = r_dig[1*DIG_W +: DIG_W];
  assign bus.dig3 = r_dig[2*DIG_W +: DIG_W];
  assign bus.dig4 = r_dig[3*DIG_W +: DIG_W];

endmodule

// File: tb/tb_freq_bcd_conv.sv
// Directed bench for freq_bcd_conv: table of conversions plus hand-written corner sequences.
// Latency: n/a.
// Backpressure: n/a.
module tb_freq_bcd_conv;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  logic [15:0] prev_dig;
  logic        prev_ovf;

  freq_bcd_conv_if #(.BIN_W(14)) bus ();

  freq_bcd_conv #(.BIN_W(14)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [13:0] bin;
    logic [15:0] exp_dig;   // {dig4,dig3,dig2,dig1} as hex-coded BCD
    logic        exp_ovf;
  } vec_t;

  vec_t vecs [13];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [15:0] digs();
    return {bus.dig4, bus.dig3, bus.dig2, bus.dig1};
  endfunction

  // Launch one conversion from IDLE; returns cycles from the start edge to done and busy-cycle count.
  task automatic run_conv(input logic [13:0] b, output int lat, output int bcnt);
    bus.bin   = b;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    lat  = -1;
    bcnt = 0;
    for (int n = 0; n < 40; n++) begin
      if (n == 7) begin
        check("hold_dig", {16'd0, digs()}, {16'd0, prev_dig});
        check("hold_ovf", {31'd0, bus.ovf}, {31'd0, prev_ovf});
      end
      if (bus.busy) bcnt++;
      if (bus.done) begin
        lat = n;
        break;
      end
      tick();
    end
  endtask

  initial begin
    int lat;
    int bcnt;
    int ndone;
    int t_first;
    int t_second;
    logic [15:0] d_first;
    logic [15:0] d_second;

    checks = 0;
    errors = 0;
    prev_dig = 16'h0000;
    prev_ovf = 1'b0;

    vecs[0]  = '{14'd0,     16'h0000, 1'b0};
    vecs[1]  = '{14'd1234,  16'h1234, 1'b0};
    vecs[2]  = '{14'd9999,  16'h9999, 1'b0};
    vecs[3]  = '{14'd10000, 16'h9999, 1'b1};
    vecs[4]  = '{14'd16383, 16'h9999, 1'b1};
    vecs[5]  = '{14'd307,   16'h0307, 1'b0};
    vecs[6]  = '{14'd8000,  16'h8000, 1'b0};
    vecs[7]  = '{14'd42,    16'h0042, 1'b0};
    vecs[8]  = '{14'd1,     16'h0001, 1'b0};
    vecs[9]  = '{14'd90,    16'h0090, 1'b0};
    vecs[10] = '{14'd5555,  16'h5555, 1'b0};
    vecs[11] = '{14'd9876,  16'h9876, 1'b0};
    vecs[12] = '{14'd4321,  16'h4321, 1'b0};

    rst       = 1'b1;
    bus.start = 1'b0;
    bus.bin   = '0;
    tick();
    tick();
    check("rst_busy", {31'd0, bus.busy}, 32'd0);
    check("rst_done", {31'd0, bus.done}, 32'd0);
    check("rst_ovf",  {31'd0, bus.ovf},  32'd0);
    check("rst_dig",  {16'd0, digs()},   32'd0);
    rst = 1'b0;
    tick();

    // Table-driven conversions; the last entry (4321) leaves digits for the reset-abort test.
    for (int i = 0; i < 13; i++) begin
      run_conv(vecs[i].bin, lat, bcnt);
      check("latency",  lat,  32'd15);
      check("busy_len", bcnt, 32'd15);
      check("dig", {16'd0, digs()}, {16'd0, vecs[i].exp_dig});
      check("ovf", {31'd0, bus.ovf}, {31'd0, vecs[i].exp_ovf});
      prev_dig = vecs[i].exp_dig;
      prev_ovf = vecs[i].exp_ovf;
      tick();
      check("done_pulse", {31'd0, bus.done}, 32'd0);
      check("busy_after", {31'd0, bus.busy}, 32'd0);
    end

    // Reset mid-conversion: abort, clear digits, no done afterwards.
    bus.bin   = 14'd9876;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int n = 0; n < 6; n++) tick();
    rst = 1'b1;
    tick();
    check("abort_dig",  {16'd0, digs()},   32'd0);
    check("abort_busy", {31'd0, bus.busy}, 32'd0);
    check("abort_done", {31'd0, bus.done}, 32'd0);
    rst = 1'b0;
    ndone = 0;
    for (int n = 0; n < 20; n++) begin
      if (bus.done) ndone++;
      tick();
    end
    check("abort_no_done", ndone, 32'd0);
    prev_dig = 16'h0000;
    prev_ovf = 1'b0;
    run_conv(14'd9876, lat, bcnt);
    check("post_abort_lat", lat, 32'd15);
    check("post_abort_dig", {16'd0, digs()}, 32'h9876);
    tick();

    // Second start during SHIFT is ignored; exactly one done with the first value.
    bus.bin   = 14'd5678;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    ndone   = 0;
    t_first = -1;
    d_first = '0;
    for (int n = 0; n < 40; n++) begin
      if (n == 4) begin
        bus.bin   = 14'd42;
        bus.start = 1'b1;
      end
      if (n == 5) bus.start = 1'b0;
      if (bus.done) begin
        ndone++;
        if (t_first < 0) begin
          t_first = n;
          d_first = digs();
        end
      end
      tick();
    end
    check("ign_ndone", ndone,   32'd1);
    check("ign_lat",   t_first, 32'd15);
    check("ign_dig",   {16'd0, d_first}, 32'h5678);

    // start held high: back-to-back conversions with one IDLE cycle; bin change after capture is harmless.
    bus.bin   = 14'd307;
    bus.start = 1'b1;
    tick();
    ndone    = 0;
    t_first  = -1;
    t_second = -1;
    d_first  = '0;
    d_second = '0;
    for (int n = 0; n < 40; n++) begin
      if (n == 1)  bus.bin = 14'd8000;
      if (n == 16) bus.start = 1'b0;
      if (bus.done) begin
        ndone++;
        if (t_first < 0) begin
          t_first = n;
          d_first = digs();
        end else begin
          t_second = n;
          d_second = digs();
        end
      end
      tick();
    end
    check("b2b_ndone",  ndone,    32'd2);
    check("b2b_t1",     t_first,  32'd15);
    check("b2b_t2",     t_second, 32'd31);
    check("b2b_dig1",   {16'd0, d_first},  32'h0307);
    check("b2b_dig2",   {16'd0, d_second}, 32'h8000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
